// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scan controller.
package display_pkg;

  typedef logic [4:0] digit_t;

  typedef enum logic [1:0] {OFF, SHOW, BLANK} scan_state_t;

  localparam logic [7:0] SEL_OFF = 8'hFF;

  // Active-low one-hot select for a single digit position.
  function automatic logic [7:0] sel_for(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/digit_arbiter.sv
// Two-port write arbiter for the digit buffer: A has priority, B ages and
// overrides A once it has been refused MAX_WAIT consecutive cycles.
module digit_arbiter
  import display_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] idx_a,
  input  digit_t     data_a,
  input  logic       req_b,
  input  logic [2:0] idx_b,
  input  digit_t     data_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       we,
  output logic [2:0] widx,
  output digit_t     wdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              cand_a;
  logic              cand_b;
  logic              busy;
  logic              b_aged;
  logic              gnt_a_d;
  logic              gnt_b_d;
  logic [WAIT_W-1:0] wait_b;
  logic [WAIT_W-1:0] wait_b_d;

  // Handshake: a requester raises req with idx/data and holds all three until
  // its gnt is seen; the write commits on the gnt cycle. A grant cycle is the
  // commit cycle, so a new grant is only issued once no grant is high.
  always_comb begin
    cand_a   = req_a && !gnt_a;
    cand_b   = req_b && !gnt_b;
    busy     = gnt_a || gnt_b;
    b_aged   = (wait_b == WAIT_MAX);
    gnt_a_d  = !busy && cand_a && !(cand_b && b_aged);
    gnt_b_d  = !busy && cand_b && (!cand_a || b_aged);
    wait_b_d = wait_b;
    if (!req_b || gnt_b) begin
      wait_b_d = '0;
    end else if (!b_aged) begin
      wait_b_d = wait_b + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      wait_b <= '0;
    end else begin
      gnt_a  <= gnt_a_d;
      gnt_b  <= gnt_b_d;
      wait_b <= wait_b_d;
    end
  end

  assign we    = gnt_a || gnt_b;
  assign widx  = gnt_a ? idx_a : idx_b;
  assign wdata = gnt_a ? data_a : data_b;

endmodule

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: digit buffer, OFF/BLANK/SHOW scan FSM and
// registered digit select / digit code outputs.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int BLANK_CYCLES = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       req_a,
  input  logic [2:0] idx_a,
  input  logic [4:0] data_a,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [2:0] idx_b,
  input  logic [4:0] data_b,
  output logic       gnt_b,
  output logic [7:0] out_digit_select,
  output logic [4:0] out_digit_number
);

  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(N_DIGITS - 1);
  localparam logic [3:0]       N_LIM    = 4'(N_DIGITS);

  scan_state_t      state;
  scan_state_t      state_d;
  logic [2:0]       idx;
  logic [2:0]       idx_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  digit_t           digit_buf [8];
  logic             we;
  logic             write_ok;
  logic [2:0]       widx;
  digit_t           wdata;
  logic [7:0]       sel_d;
  digit_t           num_d;

  digit_arbiter #(.MAX_WAIT(MAX_WAIT)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .idx_a  (idx_a),
    .data_a (data_a),
    .req_b  (req_b),
    .idx_b  (idx_b),
    .data_b (data_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .we     (we),
    .widx   (widx),
    .wdata  (wdata)
  );

  // Writes aimed past the last scanned digit are granted but dropped.
  assign write_ok = we && ({1'b0, widx} < N_LIM);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    if (!en) begin
      state_d = OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        OFF: begin
          state_d = BLANK;
          cnt_d   = '0;
        end
        BLANK: begin
          if (cnt == CNT_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (tick) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
          end
        end
        default: state_d = OFF;
      endcase
    end

    // Outputs are registered from the next state; a write that lands on the
    // digit about to be shown is forwarded so it appears one clk after gnt.
    sel_d = (state_d == SHOW) ? sel_for(idx_d) : SEL_OFF;
    num_d = (write_ok && (widx == idx_d)) ? wdata : digit_buf[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= OFF;
      idx              <= '0;
      cnt              <= '0;
      out_digit_select <= SEL_OFF;
      out_digit_number <= '0;
      for (int i = 0; i < 8; i++) begin
        digit_buf[i] <= '0;
      end
    end else begin
      state            <= state_d;
      idx              <= idx_d;
      cnt              <= cnt_d;
      out_digit_select <= sel_d;
      out_digit_number <= num_d;
      if (write_ok) begin
        digit_buf[widx] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: cycle model feeding an expected
// queue, plus directed scan / arbitration / reset scenarios.
module tb_display_scan_ctrl;

  localparam int BLANK = 4;
  localparam int MAXW  = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic       req_a = 1'b0;
  logic [2:0] idx_a = '0;
  logic [4:0] data_a = '0;
  logic       req_b = 1'b0;
  logic [2:0] idx_b = '0;
  logic [4:0] data_b = '0;
  logic       gnt_a, gnt_b, gnt_a4, gnt_b4;
  logic [7:0] sel, sel4;
  logic [4:0] num, num4;

  int n_checks = 0;
  int n_pass   = 0;
  bit tick_on  = 0;
  int tcnt     = 0;

  display_scan_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .req_a(req_a), .idx_a(idx_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .idx_b(idx_b), .data_b(data_b), .gnt_b(gnt_b),
    .out_digit_select(sel), .out_digit_number(num)
  );

  display_scan_ctrl #(.N_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .req_a(req_a), .idx_a(idx_a), .data_a(data_a), .gnt_a(gnt_a4),
    .req_b(req_b), .idx_b(idx_b), .data_b(data_b), .gnt_b(gnt_b4),
    .out_digit_select(sel4), .out_digit_number(num4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tick_on) begin
      tcnt++;
      tick = (tcnt % 20 == 0);
    end else begin
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model of the 8-digit instance, one step per posedge.
  int         m_st = 0;
  int         m_idx = 0;
  int         m_cnt = 0;
  int         m_wait = 0;
  logic [4:0] m_buf [8];
  logic       m_ga = 0, m_gb = 0;
  logic [7:0] m_sel = 8'hFF;
  logic [4:0] m_num = 0;
  logic [14:0] exp_q [$];

  always @(posedge clk) begin
    logic       w, na, nb;
    logic [2:0] wi;
    logic [4:0] wd;
    if (rst) begin
      m_st = 0; m_idx = 0; m_cnt = 0; m_wait = 0; m_ga = 0; m_gb = 0;
      for (int i = 0; i < 8; i++) m_buf[i] = 5'h00;
    end else begin
      w  = m_ga || m_gb;
      wi = m_ga ? idx_a : idx_b;
      wd = m_ga ? data_a : data_b;
      na = 0; nb = 0;
      if (!m_ga && !m_gb) begin
        if (req_a && req_b) begin
          if (m_wait == MAXW) nb = 1; else na = 1;
        end else if (req_a) na = 1;
        else if (req_b) nb = 1;
      end
      if (!req_b || m_gb) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
      if (!en) begin
        m_st = 0; m_idx = 0; m_cnt = 0;
      end else if (m_st == 0) begin
        m_st = 1; m_cnt = 0;
      end else if (m_st == 1) begin
        if (m_cnt == BLANK - 1) begin m_st = 2; m_cnt = 0; end
        else m_cnt++;
      end else if (tick) begin
        m_st = 1; m_cnt = 0; m_idx = (m_idx + 1) % 8;
      end
      if (w) m_buf[wi] = wd;
      m_ga = na; m_gb = nb;
    end
    m_sel = (m_st == 2) ? ~(8'h01 << m_idx) : 8'hFF;
    m_num = m_buf[m_idx];
    exp_q.push_back({m_ga, m_gb, m_sel, m_num});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("cycle", {gnt_a, gnt_b, sel, num}, exp_q.pop_front());
  end

  task automatic write_a(input logic [2:0] i, input logic [4:0] d);
    bit seen = 0;
    req_a = 1; idx_a = i; data_a = d;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = gnt_a;
    end
    if (!seen) chk("gnt_a_timeout", 0, 1);
    req_a = 0;
  endtask

  task automatic write_b(input logic [2:0] i, input logic [4:0] d);
    bit seen = 0;
    req_b = 1; idx_b = i; data_b = d;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = gnt_b;
    end
    if (!seen) chk("gnt_b_timeout", 0, 1);
    else chk("gnt_b_n4", gnt_b4, 1);
    req_b = 0;
  endtask

  // Returns at the negedge where sel first becomes v.
  task automatic wait_sel(input logic [7:0] v, input string tag);
    logic [7:0] prev = sel;
    bit hit = 0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(negedge clk);
      hit = (sel == v) && (prev != v);
      prev = sel;
    end
    if (!hit) chk(tag, sel, v);
  endtask

  initial begin
    logic [7:0] prev, exp_sel, one;
    int nshow, run, a_cnt, bad;
    bit b_seen;

    @(negedge clk); @(negedge clk);
    chk("rst_sel", sel, 8'hFF);
    chk("rst_num", num, 5'h00);
    chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    rst = 0;

    // Scan order and blank gap length.
    en = 1; tick_on = 1;
    prev = sel; nshow = 0; run = 0; one = 8'h01;
    for (int c = 0; c < 1000 && nshow < 9; c++) begin
      @(negedge clk);
      if (sel == 8'hFF) run++;
      else if (prev == 8'hFF) begin
        exp_sel = ~(one << (nshow % 8));
        if (nshow > 0) chk("blank_gap", run, BLANK);
        chk("scan_sel", sel, exp_sel);
        nshow++;
        run = 0;
      end
      prev = sel;
    end
    if (nshow < 9) chk("scan_timeout", nshow, 9);

    // Single A write shows on its digit.
    write_a(3'd3, 5'h1A);
    wait_sel(8'hF7, "wait_f7");
    chk("dig3_num", num, 5'h1A);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) continue;
      if ($urandom_range(0, 1)) write_a(3'(i), 5'($urandom_range(0, 15)));
      else write_b(3'(i), 5'($urandom_range(0, 15)));
    end

    // Both held: A takes every other slot until B ages out.
    repeat (3) @(negedge clk);
    req_a = 1; idx_a = 3'd1; data_a = 5'h0C;
    req_b = 1; idx_b = 3'd2; data_b = 5'h0E;
    a_cnt = 0; b_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt_b) b_seen = 1;
      if (gnt_a && !b_seen) a_cnt++;
    end
    req_a = 0; req_b = 0;
    chk("aging_b_seen", b_seen, 1);
    chk("aging_a_count", a_cnt, 8);

    // B write to the digit on screen; discard on the 4-digit instance.
    wait_sel(8'h7F, "wait_7f");
    write_b(3'd7, 5'h05);
    @(negedge clk);
    chk("dig7_sel", sel, 8'h7F);
    chk("dig7_num", num, 5'h05);
    write_b(3'd6, 5'h15);
    bad = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (sel4[7:4] != 4'hF) bad++;
      if (sel4 != 8'hFF && num4 == 5'h15) bad++;
    end
    chk("n4_discard", bad, 0);

    // en dropped mid-SHOW, then re-enabled.
    wait_sel(8'hDF, "wait_df");
    @(negedge clk);
    en = 0;
    @(negedge clk);
    chk("en_off_sel", sel, 8'hFF);
    repeat (3) @(negedge clk);
    en = 1;
    wait_sel(8'hFE, "wait_fe");
    chk("reen_num", num, m_buf[0]);
    wait_sel(8'hF7, "wait_f7b");
    chk("buf_kept", num, 5'h1A);

    // Reset mid-BLANK with A requesting.
    prev = sel; run = 0;
    for (int c = 0; c < 1000 && run == 0; c++) begin
      @(negedge clk);
      if (sel == 8'hFF && prev != 8'hFF) run = 1;
      prev = sel;
    end
    if (run == 0) chk("wait_blank", 0, 1);
    rst = 1; req_a = 1; idx_a = 3'd2; data_a = 5'h09;
    @(negedge clk);
    chk("rst2_sel", sel, 8'hFF);
    chk("rst2_num", num, 5'h00);
    chk("rst2_gnt", {gnt_a, gnt_b}, 2'b00);
    rst = 0; req_a = 0;
    wait_sel(8'hFE, "wait_fe2");
    chk("rst2_buf0", num, 5'h00);
    wait_sel(8'hF7, "wait_f7c");
    chk("rst2_buf3", num, 5'h00);

    // Random requesters that honour the hold-until-grant rule.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (gnt_a) req_a = 0;
      else if (!req_a && $urandom_range(0, 3) == 0) begin
        req_a = 1; idx_a = 3'($urandom_range(0, 7)); data_a = 5'($urandom_range(0, 31));
      end
      if (gnt_b) req_b = 0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1; idx_b = 3'($urandom_range(0, 7)); data_b = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 99) == 0) en = !en;
    end
    req_a = 0; req_b = 0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
